// File: rtl/round_scorer.sv
`default_nettype none
// ---------------------------------------------------------------------------------
// round_scorer : latches LED/button vectors on start, compares one channel per clock,
//                reports hits/point and keeps a saturating score. rev 1.0
//                Define ROUND_SCORER_MISS_PENALTY_EN to charge one point per miss.
// ---------------------------------------------------------------------------------
module round_scorer #(
    parameter  int N_CH    = 3,
    parameter  int SCORE_W = 8,
    localparam int HIT_W   = $clog2(N_CH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CH-1:0]    led,
    input  logic [N_CH-1:0]    btn,
    input  logic               clear_score,
    output logic               busy,
    output logic               done,
    output logic               point,
    output logic [HIT_W-1:0]   hits,
    output logic [SCORE_W-1:0] score
);

    localparam int IDX_W  = $clog2(N_CH);
    // Sized so score+hits (or the signed penalty form) never overflows for any legal N_CH/SCORE_W.
    localparam int CALC_W = ((SCORE_W > HIT_W) ? SCORE_W : HIT_W) + 3;
    localparam logic [CALC_W-1:0] SCORE_MAX = {{(CALC_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t             state;
    logic [N_CH-1:0]    snap_led;
    logic [N_CH-1:0]    snap_btn;
    logic [IDX_W-1:0]   idx;
    logic [HIT_W-1:0]   hit_cnt;
    logic [SCORE_W-1:0] score_next;

`ifdef ROUND_SCORER_MISS_PENALTY_EN
    logic signed [CALC_W-1:0] sum;

    always_comb begin
        sum = $signed(CALC_W'(score)) + $signed(CALC_W'(hit_cnt)) + $signed(CALC_W'(hit_cnt))
            - $signed(CALC_W'(N_CH));
        if (sum[CALC_W-1]) begin
            score_next = '0;
        end else if (sum > $signed(SCORE_MAX)) begin
            score_next = '1;
        end else begin
            score_next = sum[SCORE_W-1:0];
        end
    end
`else
    logic [CALC_W-1:0] sum;

    always_comb begin
        sum = CALC_W'(score) + CALC_W'(hit_cnt);
        if (sum > SCORE_MAX) begin
            score_next = '1;
        end else begin
            score_next = sum[SCORE_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            snap_led <= '0;
            snap_btn <= '0;
            idx      <= '0;
            hit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            point    <= 1'b0;
            hits     <= '0;
            score    <= '0;
        end else begin
            done  <= 1'b0;
            point <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_led <= led;
                        snap_btn <= btn;
                        idx      <= '0;
                        hit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (snap_led[idx] == snap_btn[idx]) begin
                        hit_cnt <= hit_cnt + 1'b1;
                    end
                    if (idx == IDX_W'(N_CH - 1)) begin
                        state <= S_REPORT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_REPORT: begin
                    done  <= 1'b1;
                    hits  <= hit_cnt;
                    point <= (hit_cnt == HIT_W'(N_CH));
                    score <= score_next;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Clear overrides the report-edge add.
            if (clear_score) begin
                score <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_round_scorer.sv
`default_nettype none
// Bench for round_scorer: two instances (SCORE_W=8 and SCORE_W=4) share stimulus and
// are checked against a round-level reference model.
module tb_round_scorer;

    localparam int N_CH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clear_score = 1'b0;
    logic [2:0] led = '0;
    logic [2:0] btn = '0;

    logic       busy, done, point;
    logic [1:0] hits;
    logic [7:0] score;
    logic       busy_s, done_s, point_s;
    logic [1:0] hits_s;
    logic [3:0] score_s;

    int checks = 0;
    int errors = 0;
    int m_score8 = 0;
    int m_score4 = 0;

    always #5 clk = ~clk;

    round_scorer #(.N_CH(N_CH), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .led(led), .btn(btn),
        .clear_score(clear_score), .busy(busy), .done(done), .point(point),
        .hits(hits), .score(score)
    );

    round_scorer #(.N_CH(N_CH), .SCORE_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .led(led), .btn(btn),
        .clear_score(clear_score), .busy(busy_s), .done(done_s), .point(point_s),
        .hits(hits_s), .score(score_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int count_hits(input logic [2:0] l, input logic [2:0] b);
        int n = 0;
        for (int i = 0; i < N_CH; i++) if (l[i] == b[i]) n++;
        return n;
    endfunction

    function automatic int next_score(input int s, input int h, input int w, input bit clr);
        int r;
        int mx = (1 << w) - 1;
        if (clr) return 0;
`ifdef ROUND_SCORER_MISS_PENALTY_EN
        r = s + h - (N_CH - h);
`else
        r = s + h;
`endif
        if (r < 0) r = 0;
        if (r > mx) r = mx;
        return r;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_point"}, int'(point), 0);
        chk({tag, "_hits"}, int'(hits), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_score_s"}, int'(score_s), 0);
    endtask

    // One full round starting from IDLE; all inputs driven and outputs sampled at negedge.
    task automatic run_round(input string tag, input logic [2:0] l, input logic [2:0] b,
                             input bit clr, input bit noisy);
        int h;
        h = count_hits(l, b);
        @(negedge clk);
        chk({tag, "_pre_busy"}, int'(busy), 0);
        start = 1'b1; led = l; btn = b; clear_score = 1'b0;
        @(negedge clk);
        chk({tag, "_e0_busy"}, int'(busy), 1);
        chk({tag, "_e0_done"}, int'(done), 0);
        start = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (noisy) begin
                led = 3'($urandom); btn = 3'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            chk({tag, "_chk_busy"}, int'(busy), 1);
            chk({tag, "_chk_done"}, int'(done), 0);
        end
        start = 1'b0;
        clear_score = clr;
        @(negedge clk);
        clear_score = 1'b0;
        m_score8 = next_score(m_score8, h, 8, clr);
        m_score4 = next_score(m_score4, h, 4, clr);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_point"}, int'(point), (h == N_CH) ? 1 : 0);
        chk({tag, "_hits"}, int'(hits), h);
        chk({tag, "_score"}, int'(score), m_score8);
        chk({tag, "_score_s"}, int'(score_s), m_score4);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_hits_s"}, int'(hits_s), h);
        chk({tag, "_done_s"}, int'(done_s), 1);
        @(negedge clk);
        chk({tag, "_post_done"}, int'(done), 0);
        chk({tag, "_post_point"}, int'(point), 0);
        chk({tag, "_post_busy"}, int'(busy), 0);
        chk({tag, "_post_hits"}, int'(hits), h);
    endtask

    task automatic clear_now(input string tag);
        @(negedge clk);
        clear_score = 1'b1;
        @(negedge clk);
        clear_score = 1'b0;
        m_score8 = 0;
        m_score4 = 0;
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_score_s"}, int'(score_s), 0);
    endtask

    typedef struct {
        logic [2:0] led;
        logic [2:0] btn;
        bit         clr;
        bit         noisy;
        int         exp_hits;
        bit         exp_point;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int ndone;
        vecs[0] = '{3'b000, 3'b000, 1'b0, 1'b0, 3, 1'b1};
        vecs[1] = '{3'b111, 3'b000, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{3'b001, 3'b000, 1'b0, 1'b1, 2, 1'b0};
        vecs[3] = '{3'b100, 3'b110, 1'b0, 1'b0, 2, 1'b0};
        vecs[4] = '{3'b010, 3'b011, 1'b1, 1'b0, 2, 1'b0};
        vecs[5] = '{3'b111, 3'b111, 1'b0, 1'b1, 3, 1'b1};
        vecs[6] = '{3'b011, 3'b100, 1'b0, 1'b0, 0, 1'b0};
        vecs[7] = '{3'b110, 3'b100, 1'b0, 1'b0, 2, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b1;

        // Clamp case from zero score with no hits
        run_round("zero_miss", 3'b000, 3'b111, 1'b0, 1'b0);
        chk("zero_miss_const", int'(score), 0);

        // Perfect round then partial round
        run_round("perfect", 3'b101, 3'b101, 1'b0, 1'b0);
        chk("perfect_const", int'(score), 3);
        run_round("partial", 3'b110, 3'b011, 1'b0, 1'b0);
`ifdef ROUND_SCORER_MISS_PENALTY_EN
        chk("partial_const", int'(score), 2);
`else
        chk("partial_const", int'(score), 4);
`endif

        // Reset in the middle of CHECK aborts the round
        @(negedge clk);
        start = 1'b1; led = 3'b111; btn = 3'b111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_zero("midreset");
        m_score8 = 0;
        m_score4 = 0;
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        run_round("after_reset", 3'b011, 3'b011, 1'b0, 1'b0);

        // Snapshot and ignored start while busy
        run_round("noisy", 3'b010, 3'b110, 1'b0, 1'b1);

        // Saturation on the 4-bit instance
        clear_now("sat_clr");
        for (int r = 1; r <= 6; r++) begin
            run_round("sat", 3'b110, 3'b110, 1'b0, 1'b0);
            chk("sat_const", int'(score_s), (r * 3 > 15) ? 15 : r * 3);
        end

        // Clear on the REPORT edge beats the add
        clear_now("rpt_clr");
        run_round("six_a", 3'b001, 3'b001, 1'b0, 1'b0);
        run_round("six_b", 3'b001, 3'b001, 1'b0, 1'b0);
        chk("six_const", int'(score), 6);
        run_round("rpt_clear", 3'b101, 3'b101, 1'b1, 1'b0);
        chk("rpt_clear_const", int'(score), 0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_round("vec", vecs[i].led, vecs[i].btn, vecs[i].clr, vecs[i].noisy);
            chk("vec_hits", int'(hits), vecs[i].exp_hits);
            chk("vec_point", int'(point_s), 0);
            chk("vec_point_last", (count_hits(vecs[i].led, vecs[i].btn) == N_CH) ? 1 : 0,
                int'(vecs[i].exp_point));
        end

        // Randomized rounds
        for (int i = 0; i < 40; i++) begin
            run_round("rand", 3'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0),
                      1'($urandom));
        end

        // start held high: one round every N_CH+2 cycles
        clear_now("cont_clr");
        @(negedge clk);
        start = 1'b1; led = 3'b111; btn = 3'b111;
        ndone = 0;
        for (int c = 0; c < 5 * (N_CH + 2); c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                m_score8 = next_score(m_score8, 3, 8, 1'b0);
                m_score4 = next_score(m_score4, 3, 4, 1'b0);
                chk("cont_score", int'(score), m_score8);
            end
        end
        start = 1'b0;
        chk("cont_ndone", ndone, 5);
        chk("cont_score_s", int'(score_s), m_score4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
